// File: rtl/prei_pkg.sv
// rtl/prei_pkg.sv - shared prei constants and original-pixel read FSM encoding
package prei_pkg;

    localparam int PREI_ORG_ADDR_W = 4;
    localparam int PREI_ORG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } prei_rd_state_t;

endpackage

// File: rtl/prei_rd_skid_fifo.sv
// rtl/prei_rd_skid_fifo.sv - 2-entry skid FIFO (data+last) with fall-through when empty
module prei_rd_skid_fifo
    import prei_pkg::*;
#(
    parameter int WIDTH = PREI_ORG_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             empty;
    logic             do_write;
    logic             do_read;

    // An empty FIFO forwards the incoming word so the consumer sees RAM data the cycle it arrives.
    assign empty      = (count == 2'd0);
    assign head_valid = !empty || push;
    assign head_data  = !empty ? mem[rd_ptr] : (push ? push_data : '0);
    assign do_read    = pop && !empty;
    assign do_write   = push && !(empty && pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_read) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_write} - {1'b0, do_read};
        end
    end

endmodule

// File: rtl/prei_org_rd_ctrl.sv
// rtl/prei_org_rd_ctrl.sv - prei original-pixel RAM read controller with backpressured stream output
// Optional stall cycle counter output enabled by defining PREI_RD_STALL_CNT_EN.
module prei_org_rd_ctrl
    import prei_pkg::*;
#(
    parameter int ADDR_WIDTH = PREI_ORG_ADDR_W,
    parameter int DATA_WIDTH = PREI_ORG_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_ena_o,
    output logic [ADDR_WIDTH-1:0] rd_adr_o,
    input  logic [DATA_WIDTH-1:0] rd_dat_i,
    output logic                  dat_val_o,
    input  logic                  dat_rdy_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  dat_last_o
`ifdef PREI_RD_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt_o
`endif
);

    prei_rd_state_t        state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  in_flight;
    logic                  in_flight_last;
    logic [1:0]            fifo_count;
    logic [1:0]            occupancy;
    logic                  rd_issue;
    logic                  start_ok;
    logic [DATA_WIDTH:0]   head_data;

    // Words in flight plus words buffered never exceed the two FIFO slots.
    assign occupancy = fifo_count + {1'b0, in_flight};
    assign rd_issue  = (state == ST_READ) && (occupancy < 2'd2);
    assign rd_ena_o  = ~rd_issue;
    assign busy_o    = (state != ST_IDLE);
    assign start_ok  = (state == ST_IDLE) && start_i;

    assign dat_o      = head_data[DATA_WIDTH-1:0];
    assign dat_last_o = head_data[DATA_WIDTH];
    assign done_o     = (state == ST_DRAIN) && dat_val_o && dat_rdy_i && dat_last_o;

    prei_rd_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (in_flight),
        .push_data  ({in_flight_last, rd_dat_i}),
        .pop        (dat_rdy_i),
        .head_valid (dat_val_o),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            len_q          <= '0;
            rd_adr_o       <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= rd_issue;
            in_flight_last <= rd_issue && (rd_adr_o == len_q);
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        rd_adr_o <= '0;
                        state    <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Address parks on the last word so len_i = max never wraps.
                    if (rd_issue) begin
                        if (rd_adr_o == len_q) begin
                            state <= ST_DRAIN;
                        end else begin
                            rd_adr_o <= rd_adr_o + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (done_o) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PREI_RD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= 16'd0;
        end else if (start_ok) begin
            stall_cnt_o <= 16'd0;
        end else if (busy_o && dat_val_o && !dat_rdy_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prei_org_rd_ctrl.sv
// tb/tb_prei_org_rd_ctrl.sv - self-checking bench for prei_org_rd_ctrl with RAM model and scoreboard
module tb_prei_org_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  len_i = 4'd0;
    logic        busy_o, done_o, rd_ena_o, dat_val_o, dat_last_o;
    logic [3:0]  rd_adr_o;
    logic [31:0] rd_dat_i = 32'd0;
    logic        dat_rdy_i = 1'b0;
    logic [31:0] dat_o;
`ifdef PREI_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    prei_org_rd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rd_ena_o   (rd_ena_o),
        .rd_adr_o   (rd_adr_o),
        .rd_dat_i   (rd_dat_i),
        .dat_val_o  (dat_val_o),
        .dat_rdy_i  (dat_rdy_i),
        .dat_o      (dat_o),
        .dat_last_o (dat_last_o)
`ifdef PREI_RD_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    // Synchronous-read RAM: data appears one cycle after a low-active enable.
    logic [31:0] ram [16];
    always @(posedge clk) if (!rd_ena_o) rd_dat_i <= ram[rd_adr_o];

    int total = 0;
    int bad = 0;
    int rel_k = 0;
    int done_cnt, done_k, issued, popped, max_ahead, stable_err;
    int rd_adr_q[$];
    int rd_k_q[$];
    logic [32:0] got_q[$];
    int got_k_q[$];
    logic prev_stall = 1'b0;
    logic [32:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (!rd_ena_o) begin
                rd_adr_q.push_back(int'(rd_adr_o));
                rd_k_q.push_back(rel_k);
                issued++;
            end
            if (dat_val_o && dat_rdy_i) begin
                got_q.push_back({dat_last_o, dat_o});
                got_k_q.push_back(rel_k);
                popped++;
            end
            if (issued - popped > max_ahead) max_ahead = issued - popped;
            if (prev_stall && (!dat_val_o || {dat_last_o, dat_o} !== prev_word)) stable_err++;
            prev_stall = dat_val_o && !dat_rdy_i;
            prev_word  = {dat_last_o, dat_o};
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) done_k = rel_k;
            end
        end
    end

    function automatic logic rdy_for(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return !(k >= 3 && k <= 8);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Pulse start in cycle 0, run until one cycle past done_o, then score delivered words.
    task automatic run_op(input int len, input int mode, input bit spam);
        logic [32:0] exp;
        int n;
        rd_adr_q.delete(); rd_k_q.delete(); got_q.delete(); got_k_q.delete();
        issued = 0; popped = 0; max_ahead = 0; stable_err = 0; done_cnt = 0; done_k = -1;
        rel_k = 0;
        start_i = 1'b1;
        len_i = 4'(len);
        dat_rdy_i = rdy_for(mode, 0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            rel_k = k;
            start_i = spam && (k == 2 || k == len + 2);
            if (spam) len_i = 4'd9;
            dat_rdy_i = rdy_for(mode, k);
            if (done_k >= 0) break;
        end
        start_i = 1'b0;
        total++;
        if (done_k < 0) begin
            bad++;
            $display("FAIL op_timeout len=%0d: no done_o within budget", len);
        end
        total++;
        if (got_q.size() != len + 1) begin
            bad++;
            $display("FAIL word_count len=%0d: got %0d need %0d", len, got_q.size(), len + 1);
        end
        n = (got_q.size() < len + 1) ? got_q.size() : len + 1;
        for (int i = 0; i < n; i++) begin
            exp = {(i == len), ram[i]};
            total++;
            if (got_q[i] !== exp) begin
                bad++;
                $display("FAIL word%0d: got %h need %h", i, got_q[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b need 0", busy_o); end
        total++; if (done_o !== 1'b0)     begin bad++; $display("FAIL rst_done: got %b need 0", done_o); end
        total++; if (rd_ena_o !== 1'b1)   begin bad++; $display("FAIL rst_rd_ena: got %b need 1", rd_ena_o); end
        total++; if (rd_adr_o !== 4'd0)   begin bad++; $display("FAIL rst_rd_adr: got %0d need 0", rd_adr_o); end
        total++; if (dat_val_o !== 1'b0)  begin bad++; $display("FAIL rst_dat_val: got %b need 0", dat_val_o); end
        total++; if (dat_o !== 32'd0)     begin bad++; $display("FAIL rst_dat: got %h need 0", dat_o); end
        total++; if (dat_last_o !== 1'b0) begin bad++; $display("FAIL rst_last: got %b need 0", dat_last_o); end
`ifdef PREI_RD_STALL_CNT_EN
        total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt: got %0d need 0", stall_cnt_o); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_stream();
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        run_op(15, 0, 1'b0);
        total++;
        if (rd_adr_q.size() != 16) begin bad++; $display("FAIL full_reads: got %0d need 16", rd_adr_q.size()); end
        for (int i = 0; i < rd_adr_q.size() && i < 16; i++) begin
            total++;
            if (rd_adr_q[i] != i || rd_k_q[i] != i + 1) begin
                bad++;
                $display("FAIL full_rd%0d: adr %0d at cycle %0d need adr %0d at cycle %0d", i, rd_adr_q[i], rd_k_q[i], i, i + 1);
            end
        end
        total++;
        if (got_k_q.size() == 0 || got_k_q[0] != 2) begin bad++; $display("FAIL full_first_valid: need first word at cycle 2"); end
        total++; if (done_k != 17) begin bad++; $display("FAIL full_done_cycle: got %0d need 17", done_k); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL full_busy_after: got %b need 0", busy_o); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done_count: got %0d need 1", done_cnt); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        run_op(3, 1, 1'b0);
        total++; if (max_ahead > 2)   begin bad++; $display("FAIL stall_ahead: got %0d need <=2", max_ahead); end
        total++; if (stable_err != 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles need 0", stable_err); end
        total++; if (done_cnt != 1)   begin bad++; $display("FAIL stall_done_count: got %0d need 1", done_cnt); end
`ifdef PREI_RD_STALL_CNT_EN
        total++; if (stall_cnt_o !== 16'd6) begin bad++; $display("FAIL stall_cnt: got %0d need 6", stall_cnt_o); end
`endif
    endtask

    task automatic test_random_ready();
        for (int i = 0; i < 16; i++) ram[i] = 32'hA500_0000 + i;
        for (int r = 0; r < 3; r++) begin
            run_op(15, 2, 1'b0);
            total++; if (max_ahead > 2)   begin bad++; $display("FAIL rand_ahead r%0d: got %0d need <=2", r, max_ahead); end
            total++; if (stable_err != 0) begin bad++; $display("FAIL rand_hold r%0d: got %0d need 0", r, stable_err); end
            total++; if (done_cnt != 1)   begin bad++; $display("FAIL rand_done_count r%0d: got %0d need 1", r, done_cnt); end
        end
    endtask

    task automatic test_ignored_start();
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        run_op(3, 0, 1'b1);
        total++; if (done_k != 5)     begin bad++; $display("FAIL ign_done_cycle: got %0d need 5", done_k); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL ign_busy_after: got %b need 0", busy_o); end
        total++; if (done_cnt != 1)   begin bad++; $display("FAIL ign_done_count: got %0d need 1", done_cnt); end
        run_op(0, 0, 1'b0);
        total++; if (done_k != 2)     begin bad++; $display("FAIL ign_restart_done: got %0d need 2", done_k); end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        start_i = 1'b1; len_i = 4'd15; dat_rdy_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (rd_ena_o !== 1'b0) begin bad++; $display("FAIL mid_reading: got rd_ena %b need 0", rd_ena_o); end
        done_cnt = 0;
        rst = 1'b1;
        #1;
        total++; if (rd_ena_o !== 1'b1)  begin bad++; $display("FAIL mid_rst_rd_ena: got %b need 1", rd_ena_o); end
        total++; if (dat_val_o !== 1'b0) begin bad++; $display("FAIL mid_rst_dat_val: got %b need 0", dat_val_o); end
        total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL mid_rst_busy: got %b need 0", busy_o); end
        total++; if (done_o !== 1'b0)    begin bad++; $display("FAIL mid_rst_done: got %b need 0", done_o); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_no_done: got %0d need 0", done_cnt); end
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_single_word();
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        run_op(0, 0, 1'b0);
        total++;
        if (rd_adr_q.size() != 1 || rd_adr_q[0] != 0) begin
            bad++;
            $display("FAIL single_reads: got %0d reads need 1 read of adr 0", rd_adr_q.size());
        end
        total++; if (done_k != 2)   begin bad++; $display("FAIL single_done_cycle: got %0d need 2", done_k); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count: got %0d need 1", done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'd0;
        test_reset();
        test_full_stream();
        test_stall();
        test_random_ready();
        test_ignored_start();
        test_reset_mid_read();
        test_single_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
